// File: rtl/keypad_debounce_encoder_pkg.sv
// Shared types and helpers for the keypad debounce/encoder slice.
// Holds the FSM state type, key codes and the one-hot check.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_CYCLES   = 256;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  function automatic logic onehot4_valid(
    input logic [3:0] vec
  );
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < 4; i++)
      ones = ones + {2'b00, vec[i]};
    return (ones == 3'd1);
  endfunction

endpackage

// File: rtl/keypad_debounce_encoder_if.sv
// Scanner-side bundle: scan phase/column read in,
// debounced key strobe and scan freeze out.
interface keypad_debounce_encoder_if;
  logic [3:0] row_line;
  logic [3:0] col_line;
  logic       scan_hold;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (
    output row_line,
    output col_line,
    input  scan_hold,
    input  key_valid,
    input  key_code,
    input  key_held
  );

  modport slave (
    input  row_line,
    input  col_line,
    output scan_hold,
    output key_valid,
    output key_code,
    output key_held
  );
endinterface

// File: rtl/keypad_debounce_encoder_onehot4_enc.sv
// 4-bit one-hot to 2-bit index encoder with an
// exactly-one-bit-set valid flag.
module onehot4_enc
  import keypad_pkg::*;
(
  input  logic [3:0] vec,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    idx = 2'd0;
    unique case (vec)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  assign valid = onehot4_valid(vec);

endmodule

// File: rtl/keypad_debounce_encoder.sv
// Keypad debounce + hex encoder behind the 4x4 scanner.
// Optional auto-repeat enabled by defining KEY_REPEAT_EN.
module keypad_debounce_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input logic                      clk,
  input logic                      rst,
  keypad_debounce_encoder_if.slave kp
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2)
  begin : g_bad_param
    $error("keypad: illegal parameter value");
  end

  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic       row_ok;
  logic       col_ok;

  onehot4_enc u_row_enc (
    .vec  (kp.row_line),
    .idx  (row_idx),
    .valid(row_ok)
  );

  onehot4_enc u_col_enc (
    .vec  (kp.col_line),
    .idx  (col_idx),
    .valid(col_ok)
  );

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    snap_row;
  logic [3:0]    snap_col;
  logic [1:0]    snap_s;
  logic [1:0]    snap_r;
  logic          scan_hold;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_held;

  logic match;
  logic col_zero;

  assign match = (kp.row_line == snap_row) &&
                 (kp.col_line == snap_col);
  assign col_zero = (kp.col_line == 4'd0);

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RLAST =
    RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      snap_row  <= 4'd0;
      snap_col  <= 4'd0;
      snap_s    <= 2'd0;
      snap_r    <= 2'd0;
      scan_hold <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep       <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (row_ok && col_ok) begin
            snap_row  <= kp.row_line;
            snap_col  <= kp.col_line;
            snap_s    <= row_idx;
            snap_r    <= col_idx;
            cnt       <= '0;
            scan_hold <= 1'b1;
            state     <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            cnt       <= '0;
            scan_hold <= 1'b0;
            state     <= IDLE;
          end else if (cnt == LAST) begin
            key_code  <= {snap_r, snap_s};
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            cnt       <= '0;
            state     <= PRESSED;
`ifdef KEY_REPEAT_EN
            rep       <= '0;
`endif
          end else begin
            // cnt stops at LAST, so it never wraps
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (col_zero) begin
            cnt   <= '0;
            state <= RELEASE;
`ifdef KEY_REPEAT_EN
            rep   <= '0;
          end else if (rep == RLAST) begin
            key_valid <= 1'b1;
            rep       <= '0;
          end else begin
            rep <= rep + 1'b1;
`endif
          end
        end
        RELEASE: begin
          if (!col_zero) begin
            cnt   <= '0;
            state <= PRESSED;
          end else if (cnt == LAST) begin
            cnt       <= '0;
            scan_hold <= 1'b0;
            key_held  <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kp.scan_hold = scan_hold;
  assign kp.key_valid = key_valid;
  assign kp.key_code  = key_code;
  assign kp.key_held  = key_held;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Self-checking bench for keypad_debounce_encoder with a
// sample-history reference model and random stimulus.
module tb_keypad_debounce_encoder;
  import keypad_pkg::*;

  localparam int D = 4;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_debounce_encoder_if kp();

  keypad_debounce_encoder #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  int tests = 0;
  int fails = 0;

  // Model: "busy" = a candidate key is frozen,
  // "down" = it was accepted; run/zeros count samples.
  bit         m_busy;
  bit         m_down;
  bit         m_valid;
  logic [3:0] m_code;
  logic [3:0] m_sr;
  logic [3:0] m_sc;
  int         m_run;
  int         m_zeros;
  int         m_since;

  function automatic int bit_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit is_oh(input logic [3:0] v);
    return $countones(v) == 1;
  endfunction

  function void model_reset();
    m_busy = 0; m_down = 0; m_valid = 0;
    m_code = 4'd0; m_sr = 4'd0; m_sc = 4'd0;
    m_run = 0; m_zeros = 0; m_since = 0;
  endfunction

  function void model_step(
    input logic [3:0] r,
    input logic [3:0] c
  );
    int code;
    m_valid = 0;
    if (!m_busy) begin
      if (is_oh(r) && is_oh(c)) begin
        m_busy = 1; m_sr = r; m_sc = c; m_run = 0;
      end
    end else if (!m_down) begin
      if (r == m_sr && c == m_sc) begin
        m_run++;
        if (m_run == D) begin
          code = 4 * bit_idx(m_sc) + bit_idx(m_sr);
          m_code = 4'(code);
          m_down = 1; m_valid = 1;
          m_zeros = 0; m_since = 0;
        end
      end else begin
        m_busy = 0;
      end
    end else if (c == 4'd0) begin
      m_zeros++;
      m_since = 0;
      if (m_zeros == D + 1) begin
        m_busy = 0; m_down = 0;
      end
    end else begin
      if (m_zeros == 0) begin
        m_since++;
`ifdef KEY_REPEAT_EN
        if (m_since == R) begin
          m_valid = 1; m_since = 0;
        end
`endif
      end else begin
        m_since = 0;
      end
      m_zeros = 0;
    end
  endfunction

  function automatic logic [6:0] got_vec();
    return {kp.scan_hold, kp.key_valid,
            kp.key_code, kp.key_held};
  endfunction

  function automatic logic [6:0] exp_vec();
    return {m_busy, m_valid, m_code, m_down};
  endfunction

  task automatic tick(
    input logic [3:0] r,
    input logic [3:0] c
  );
    kp.row_line = r;
    kp.col_line = c;
    @(posedge clk);
    model_step(r, c);
    @(negedge clk);
  endtask

  task automatic test_reset();
    kp.row_line = 4'd0;
    kp.col_line = 4'd0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (got_vec() !== 7'd0) begin
      fails++;
      $display("FAIL reset: got %b want %b",
               got_vec(), 7'd0);
    end
    rst = 1'b0;
    tick(4'd0, 4'd0);
    tests++;
    if (got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_idle: got %b want %b",
               got_vec(), exp_vec());
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick(4'b0001, 4'b0100);
      tests++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL clean_cyc%0d: got %b want %b",
                 i, got_vec(), exp_vec());
      end
      if (kp.key_valid === 1'b1) begin
        nv++;
        if (first < 0) first = i;
      end
    end
    tests++;
    if (first != D) begin
      fails++;
      $display("FAIL clean_latency: got %0d want %0d",
               first, D);
    end
    tests++;
    if (nv != 1) begin
      fails++;
      $display("FAIL clean_count: got %0d want 1", nv);
    end
    tests++;
    if (kp.key_code !== KEY_8) begin
      fails++;
      $display("FAIL clean_code: got %h want %h",
               kp.key_code, KEY_8);
    end
    for (int i = 0; i < 8; i++) begin
      tick(4'b0000, 4'b0000);
      tests++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL clean_rel%0d: got %b want %b",
                 i, got_vec(), exp_vec());
      end
    end
    tests++;
    if ({kp.scan_hold, kp.key_held, kp.key_code}
        !== {2'b00, KEY_8}) begin
      fails++;
      $display("FAIL clean_idle: got %b%b %h want 00 8",
               kp.scan_hold, kp.key_held, kp.key_code);
    end
  endtask

  task automatic test_press_bounce();
    logic [3:0] cs [6];
    int nv = 0;
    cs = '{4'b0010, 4'b0010, 4'b0000,
           4'b0010, 4'b0010, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      tick(4'b0001, cs[i]);
      tests++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL bounce_cyc%0d: got %b want %b",
                 i, got_vec(), exp_vec());
      end
      if (kp.key_valid === 1'b1) nv++;
    end
    tests++;
    if (nv != 0 || kp.scan_hold !== 1'b0) begin
      fails++;
      $display("FAIL bounce_none: got %0d/%b want 0/0",
               nv, kp.scan_hold);
    end
  endtask

  task automatic test_multi_key();
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0100, 4'b0011);
      if (kp.scan_hold !== 1'b0 ||
          kp.key_valid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL multi_key: got %0d bad want 0",
               bad);
    end
  endtask

  task automatic test_release_bounce();
    int nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick(4'b0100, 4'b1000);
      if (kp.key_valid === 1'b1) nv++;
    end
    repeat (3) tick(4'b0100, 4'b0000);
    tick(4'b0100, 4'b1000);
    tests++;
    if (got_vec() !== exp_vec() ||
        kp.key_held !== 1'b1) begin
      fails++;
      $display("FAIL relb_back: got %b want %b",
               got_vec(), exp_vec());
    end
    if (kp.key_valid === 1'b1) nv++;
    repeat (3) begin
      tick(4'b0100, 4'b1000);
      if (kp.key_valid === 1'b1) nv++;
    end
    repeat (D + 2) tick(4'b0100, 4'b0000);
    tests++;
    if (nv != 1) begin
      fails++;
      $display("FAIL relb_count: got %0d want 1", nv);
    end
    tests++;
    if ({kp.scan_hold, kp.key_held, kp.key_code}
        !== {2'b00, KEY_E}) begin
      fails++;
      $display("FAIL relb_idle: got %b%b %h want 00 e",
               kp.scan_hold, kp.key_held, kp.key_code);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int first = -1;
    repeat (3) tick(4'b0010, 4'b0001);
    rst = 1'b1;
    #1;
    model_reset();
    tests++;
    if (got_vec() !== 7'd0) begin
      fails++;
      $display("FAIL rstmid_zero: got %b want 0",
               got_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(4'b0010, 4'b0001);
      tests++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL rstmid_cyc%0d: got %b want %b",
                 i, got_vec(), exp_vec());
      end
      if (kp.key_valid === 1'b1 && first < 0)
        first = i;
    end
    tests++;
    if (first != D || kp.key_code !== KEY_1) begin
      fails++;
      $display("FAIL rstmid_fresh: got %0d/%h want %0d/1",
               first, kp.key_code, D);
    end
    repeat (D + 2) tick(4'b0000, 4'b0000);
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] c;
    logic       prev_v = 1'b0;
    int         len;
    int         errs = 0;
    int         dbl = 0;
    for (int e = 0; e < 150; e++) begin
      len = $urandom_range(1, 12);
      r = 4'b0001 << $urandom_range(0, 3);
      c = 4'b0001 << $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: c = 4'd0;
        1: c = 4'($urandom_range(0, 15));
        default: ;
      endcase
      for (int i = 0; i < len; i++) begin
        tick(r, c);
        if (got_vec() !== exp_vec()) begin
          errs++;
          if (errs < 5)
            $display("FAIL rand_e%0d: got %b want %b",
                     e, got_vec(), exp_vec());
        end
        if (prev_v && kp.key_valid === 1'b1) dbl++;
        prev_v = kp.key_valid;
      end
    end
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL rand_model: got %0d errs want 0",
               errs);
    end
    tests++;
    if (dbl != 0) begin
      fails++;
      $display("FAIL rand_double: got %0d want 0", dbl);
    end
    repeat (D + 2) tick(4'b0000, 4'b0000);
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat();
    int offs[$];
    int acc = -1;
    for (int i = 0; i < D + 1 + 30; i++) begin
      tick(4'b1000, 4'b1000);
      if (kp.key_valid === 1'b1) begin
        if (acc < 0) acc = i;
        offs.push_back(i - acc);
        tests++;
        if (kp.key_code !== KEY_F) begin
          fails++;
          $display("FAIL rep_code: got %h want f",
                   kp.key_code);
        end
      end
    end
    tests++;
    if (offs.size() != 4 || offs[0] != 0 ||
        offs[1] != 8 || offs[2] != 16 ||
        offs[3] != 24) begin
      fails++;
      $display("FAIL rep_times: got %p want 0 8 16 24",
               offs);
    end
    repeat (D + 2) tick(4'b0000, 4'b0000);
  endtask
`endif

  initial begin
    kp.row_line = 4'd0;
    kp.col_line = 4'd0;
    model_reset();
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_multi_key();
    test_release_bounce();
    test_reset_mid_debounce();
    test_random();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
